// File: rtl/slave_port_if.sv
// Serial bus between the address-decoding master side and one slave port.
// The master drives the outbound serial stream and its qualifier; the slave
// returns the serial read stream, its qualifier and the idle/ready flag.
interface slave_port_if;
    logic swdata;   // serial address / write-data bit, LSB first
    logic smode;    // 0 = read, 1 = write; meaningful with the first address bit
    logic mvalid;   // swdata qualifier for this slave
    logic srdata;   // serial read-data bit, LSB first
    logic svalid;   // srdata qualifier
    logic sready;   // slave idle and able to take a new transaction

    modport master (
        output swdata,
        output smode,
        output mvalid,
        input  srdata,
        input  svalid,
        input  sready
    );

    modport slave (
        input  swdata,
        input  smode,
        input  mvalid,
        output srdata,
        output svalid,
        output sready
    );
endinterface

// File: rtl/slave_port.sv
// Serial-to-parallel slave port. Receives a serial address (and write data)
// from the bus, performs a single write or read on a local synchronous
// memory, and returns read data serially, LSB first.
module slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    slave_port_if.slave           bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // One counter serves address bits, data bits, the read wait and the
    // serial send, so it must reach the larger of the two widths.
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WRITE = 3'd3,
        MEMRD = 3'd4,
        SEND  = 3'd5
    } state_t;

    state_t                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  mode_q,   mode_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0] rd_q,     rd_d;

    // Combinational outputs decoded from the current state.
    logic                  wen_c;
    logic                  svalid_c;
    logic                  sready_c;
    logic                  srdata_c;

    // Load strobes: a bus bit is taken only while receiving and only when
    // the decoder qualifies it; any other time the registers hold (stall).
    logic                  addr_load;
    logic                  wdata_load;

    // Candidate register contents with the incoming bit placed at the
    // position selected by the shared counter.
    logic [ADDR_WIDTH-1:0] addr_shift;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic [DATA_WIDTH-1:0] rd_sel;

    assign addr_load  = bus.mvalid && ((state_q == IDLE) || (state_q == ADDR));
    assign wdata_load = bus.mvalid && (state_q == WDATA);

    genvar gi;

    // Address bit gi takes the bus bit when the counter points at it; the
    // counter is 0 in IDLE so the first bit always lands in position 0.
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr
            assign addr_shift[gi] = (addr_load && (cnt_q == CNT_W'(gi)))
                                    ? bus.swdata : addr_q[gi];
        end
    endgenerate

    // Write-data bit gi takes the bus bit when the counter points at it.
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_wdata
            assign wdata_shift[gi] = (wdata_load && (cnt_q == CNT_W'(gi)))
                                     ? bus.swdata : wdata_q[gi];
        end
    endgenerate

    // One-hot select of the read word bit currently being sent; OR-reduced
    // below so the counter width never has to match the word's index width.
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rdsel
            assign rd_sel[gi] = rd_q[gi] && (cnt_q == CNT_W'(gi));
        end
    endgenerate

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state, counter and output decode for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wen_c    = 1'b0;
        svalid_c = 1'b0;
        sready_c = 1'b0;
        srdata_c = 1'b0;

        case (state_q)
            IDLE: begin
                sready_c = 1'b1;
                if (bus.mvalid) begin
                    // First address bit; the direction travels with it.
                    addr_d  = addr_shift;
                    mode_d  = bus.smode;
                    cnt_d   = CNT_W'(1);
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (bus.mvalid) begin
                    addr_d = addr_shift;
                    if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = mode_q ? WDATA : MEMRD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            WDATA: begin
                if (bus.mvalid) begin
                    wdata_d = wdata_shift;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            WRITE: begin
                // Address and data registers are already stable here.
                wen_c   = 1'b1;
                state_d = IDLE;
            end

            MEMRD: begin
                // First cycle: memory registers the address. Second cycle:
                // its output is valid and is captured for sending.
                if (cnt_q == CNT_W'(1)) begin
                    rd_d    = mem_rdata;
                    cnt_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SEND: begin
                svalid_c = 1'b1;
                srdata_c = |rd_sel;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.srdata = srdata_c;
    assign bus.svalid = svalid_c;
    assign bus.sready = sready_c;

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wen    = wen_c;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: a bus-level timeline model sets the expected
// outputs for every cycle, a negedge process compares them, and a few literal
// latencies / received words pin the model itself.
module tb_slave_port;

    logic        clk;
    logic        rst;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic [7:0]  mem_rdata;

    slave_port_if bus ();

    slave_port #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory attached to the port: registered address, q one
    // cycle later.
    logic [7:0] bram      [0:4095];
    logic [7:0] model_mem [0:4095];

    always @(posedge clk) begin
        if (mem_wen === 1'b1) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int txn_start = 0;
    int wen_cyc   = -1;
    int rx_cnt    = 0;
    logic [7:0] rx_byte = 8'h00;

    logic        chk_en   = 1'b0;
    logic        exp_rdy  = 1'b1;
    logic        exp_wen  = 1'b0;
    logic        exp_sv   = 1'b0;
    logic        exp_sd   = 1'b0;
    logic        exp_mchk = 1'b1;
    logic [11:0] exp_a    = 12'h000;
    logic [7:0]  exp_d    = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expected timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            check("sready",  32'(bus.sready), 32'(exp_rdy));
            check("mem_wen", 32'(mem_wen),    32'(exp_wen));
            check("svalid",  32'(bus.svalid), 32'(exp_sv));
            if (exp_sv)   check("srdata",    32'(bus.srdata), 32'(exp_sd));
            if (exp_mchk) check("mem_addr",  32'(mem_addr),   32'(exp_a));
            if (exp_mchk) check("mem_wdata", 32'(mem_wdata),  32'(exp_d));
            if (mem_wen === 1'b1) wen_cyc = cyc;
            if (bus.svalid === 1'b1) begin
                rx_byte = {bus.srdata, rx_byte[7:1]};
                rx_cnt++;
            end
        end
    end

    // One bus cycle: drive inputs just after the edge and state what the
    // outputs must be during this cycle.
    task automatic step(input logic mv, input logic sw, input logic sm, input logic r,
                        input logic e_rdy, input logic e_wen, input logic e_sv, input logic e_sd,
                        input logic e_mchk, input logic [11:0] e_a, input logic [7:0] e_d);
        @(posedge clk);
        #1;
        bus.mvalid = mv;
        bus.swdata = sw;
        bus.smode  = sm;
        rst        = r;
        exp_rdy    = e_rdy;
        exp_wen    = e_wen;
        exp_sv     = e_sv;
        exp_sd     = e_sd;
        exp_mchk   = e_mchk;
        exp_a      = e_a;
        exp_d      = e_d;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
    endtask

    // Whole transaction as seen on the bus. Stall counts insert mvalid=0
    // cycles after the given bit; rst_at_send asserts reset in that SEND beat.
    task automatic txn(input logic wr, input logic [11:0] a, input logic [7:0] d,
                       input int a_stall_at, input int a_stall_n,
                       input int d_stall_at, input int d_stall_n, input int rst_at_send);
        logic [7:0] rd;
        txn_start = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            // smode only matters on the first bit; the opposite value elsewhere.
            step(1'b1, a[i], (i == 0) ? wr : ~wr, 1'b0,
                 (i == 0), 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
            if (i == a_stall_at)
                for (int k = 0; k < a_stall_n; k++)
                    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
        end
        if (wr) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b1, d[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
                if (i == d_stall_at)
                    for (int k = 0; k < d_stall_n; k++)
                        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
            end
            model_mem[a] = d;
            // Write strobe cycle; bus activity here must be ignored.
            step(1'b1, 1'($urandom), 1'($urandom), 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a, d);
        end else begin
            rd = model_mem[a];
            for (int k = 0; k < 2; k++)
                step(1'b1, 1'($urandom), 1'($urandom), 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'($urandom), 1'($urandom), (i == rst_at_send),
                     1'b0, 1'b0, 1'b1, rd[i], 1'b0, 12'h0, 8'h0);
                if (i == rst_at_send) break;
            end
        end
    endtask

    initial begin
        logic [11:0] pa;
        logic [7:0]  pd;
        for (int i = 0; i < 4096; i++) begin
            bram[i]      = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
        end
        rst        = 1'b1;
        bus.mvalid = 1'b0;
        bus.swdata = 1'b0;
        bus.smode  = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        // Reset held: idle outputs, cleared address/data.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 8'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 8'h0);
        idle(1);

        // Unstalled write: strobe in the cycle after bit 19.
        wen_cyc = -1;
        txn(1'b1, 12'h123, 8'hA5, -1, 0, -1, 0, -1);
        idle(1);
        check("wr123_latency", 32'(wen_cyc - txn_start), 32'd20);

        // Read back 0x123.
        rx_cnt = 0;
        txn(1'b0, 12'h123, 8'h00, -1, 0, -1, 0, -1);
        idle(1);
        check("rd123_bits", 32'(rx_cnt), 32'd8);
        check("rd123_word", 32'(rx_byte), 32'hA5);

        // Stalled write: 3 + 2 idle cycles inside the stream.
        wen_cyc = -1;
        txn(1'b1, 12'h0FF, 8'h3C, 5, 3, 2, 2, -1);
        idle(1);
        check("wr0ff_stalled_latency", 32'(wen_cyc - txn_start), 32'd25);

        // Read aborted by reset in the 4th SEND beat.
        rx_cnt = 0;
        txn(1'b0, 12'h0FF, 8'h00, -1, 0, -1, 0, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 8'h0);
        idle(2);
        check("rd_abort_bits", 32'(rx_cnt), 32'd4);

        // Write after the abort, then read it back.
        txn(1'b1, 12'h001, 8'h77, -1, 0, -1, 0, -1);
        rx_cnt = 0;
        txn(1'b0, 12'h001, 8'h00, -1, 0, -1, 0, -1);
        idle(1);
        check("rd001_word", 32'(rx_byte), 32'h77);

        // Boundary address, write immediately followed by read.
        rx_cnt  = 0;
        rx_byte = 8'hFF;
        txn(1'b1, 12'hFFF, 8'h00, -1, 0, -1, 0, -1);
        txn(1'b0, 12'hFFF, 8'h00, -1, 0, -1, 0, -1);
        idle(1);
        check("rdfff_bits", 32'(rx_cnt), 32'd8);
        check("rdfff_word", 32'(rx_byte), 32'h00);

        // Write aborted by reset during the data phase: no strobe, memory kept.
        pa = 12'h0AA;
        pd = 8'h55;
        for (int i = 0; i < 12; i++)
            step(1'b1, pa[i], (i == 0) ? 1'b1 : 1'b0, 1'b0,
                 (i == 0), 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
        for (int i = 0; i < 3; i++)
            step(1'b1, pd[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 8'h0);
        idle(3);
        rx_cnt = 0;
        txn(1'b0, 12'h0AA, 8'h00, -1, 0, -1, 0, -1);
        idle(1);
        check("rd0aa_word", 32'(rx_byte), 32'hF0);

        idle(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
